// File: rtl/cpu_debug_scan_pkg.sv
// Shared types and constants for the CPU debug virtual-JTAG scan host.
package cpu_debug_scan_pkg;

  localparam int unsigned DefaultDrWidth = 38;

  // IR codes understood by the CPU debug slave.
  localparam logic [1:0] IrNop    = 2'b00;
  localparam logic [1:0] IrSelect = 2'b01;
  localparam logic [1:0] IrData   = 2'b10;
  localparam logic [1:0] IrStatus = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StSdr,
    StUdr,
    StRti
  } scan_state_e;

endpackage

// File: rtl/cpu_debug_scan_tckgen.sv
// TCK generator: low for TCK_DIV cycles, high for TCK_DIV cycles, while enabled.
module cpu_debug_scan_tckgen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tck_o,
  output logic tck_rise_o,
  output logic tck_fall_o
);

  localparam int unsigned Period = 2 * TCK_DIV;
  localparam int unsigned DivW   = $clog2(Period);

  logic [DivW-1:0] div_q, div_d;
  logic            tck_d;

  always_comb begin
    div_d = '0;
    if (en_i && (div_q != DivW'(Period - 1))) begin
      div_d = div_q + 1'b1;
    end
    tck_d = en_i && (div_d >= DivW'(TCK_DIV));
  end

  // Strobes mark the clk edge at which tck_o changes.
  assign tck_rise_o = en_i && (div_q == DivW'(TCK_DIV - 1));
  assign tck_fall_o = en_i && (div_q == DivW'(Period - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      tck_o <= 1'b0;
    end else begin
      div_q <= div_d;
      tck_o <= tck_d;
    end
  end

endmodule

// File: rtl/cpu_debug_scan_host.sv
// Scan initiator driving the debug slave's virtual-JTAG strobes for one IR+DR command.
module cpu_debug_scan_host
  import cpu_debug_scan_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DefaultDrWidth,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [1:0]          rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  input  logic [1:0]          vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned CntW = $clog2(DR_WIDTH + 1);

  scan_state_e         state_q, state_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                tck_rise, tck_fall;
  logic                accept, scan_en, scan_done;

  assign accept    = cmd_valid && cmd_ready;
  assign scan_en   = (state_q != StIdle);
  assign scan_done = (state_q == StRti) && tck_fall;

  cpu_debug_scan_tckgen #(
    .TCK_DIV(TCK_DIV)
  ) u_tckgen (
    .clk_i     (clk),
    .rst_i     (reset),
    .en_i      (scan_en),
    .tck_o     (vji_tck),
    .tck_rise_o(tck_rise),
    .tck_fall_o(tck_fall)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StUir;
          sr_d    = cmd_data;
        end
      end
      StUir: if (tck_fall) state_d = StCdr;
      StCdr: if (tck_fall) state_d = StSdr;
      StSdr: begin
        if (tck_rise) begin
          sr_d  = {vji_tdo, sr_q[DR_WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
        end
        if (tck_fall && (cnt_q == CntW'(DR_WIDTH))) begin
          state_d = StUdr;
          cnt_d   = '0;
        end
      end
      StUdr: if (tck_fall) state_d = StRti;
      StRti: if (tck_fall) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= 2'b00;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= 2'b00;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b1;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      cmd_ready <= (state_d == StIdle);
      vji_uir   <= (state_d == StUir);
      vji_cdr   <= (state_d == StCdr);
      vji_sdr   <= (state_d == StSdr);
      vji_udr   <= (state_d == StUdr);
      vji_rti   <= (state_d == StIdle) || (state_d == StRti);
      rsp_valid <= scan_done;
      if (scan_done) rsp_data <= sr_q;
      if (accept) vji_ir_in <= cmd_ir;
      if ((state_q == StUir) && tck_rise) rsp_ir_out <= vji_ir_out;
      // Every state change lands on a TCK fall, so TDI only moves there.
      if (tck_fall) vji_tdi <= (state_d == StSdr) ? sr_q[0] : 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_debug_scan_host.sv
// Self-checking bench for cpu_debug_scan_host: default and minimal parameterisations.
module tb_cpu_debug_scan_host;
  import cpu_debug_scan_pkg::*;

  localparam int W   = 38;
  localparam int TD  = 2;
  localparam int LAT = 1 + (W + 4) * 2 * TD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT
  logic         reset, cmd_valid, cmd_ready, rsp_valid;
  logic [1:0]   cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
  logic [W-1:0] cmd_data, rsp_data;
  logic         vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  // Minimal DUT: TCK_DIV=1, DR_WIDTH=2, loopback
  logic       s_reset, s_cmd_valid, s_cmd_ready, s_rsp_valid;
  logic [1:0] s_cmd_ir, s_cmd_data, s_rsp_data, s_rsp_ir_out, s_ir_in, s_ir_out;
  logic       s_tck, s_tdi, s_tdo, s_uir, s_cdr, s_sdr, s_udr, s_rti;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          tdo_mode = 0;
  logic [63:0] rbits = '0;
  logic [63:0] tdi_seen = '0;
  int unsigned rise_cnt = 0;

  cpu_debug_scan_host #(.DR_WIDTH(W), .TCK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
    .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  cpu_debug_scan_host #(.DR_WIDTH(2), .TCK_DIV(1)) dut_s (
    .clk(clk), .reset(s_reset), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_ir(s_cmd_ir), .cmd_data(s_cmd_data), .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data),
    .rsp_ir_out(s_rsp_ir_out), .vji_tck(s_tck), .vji_tdi(s_tdi), .vji_tdo(s_tdo),
    .vji_ir_in(s_ir_in), .vji_ir_out(s_ir_out), .vji_uir(s_uir), .vji_cdr(s_cdr),
    .vji_sdr(s_sdr), .vji_udr(s_udr), .vji_rti(s_rti)
  );

  assign s_tdo = s_tdi;

  // Slave model: the k-th TCK rise in shift-DR sees rbits[k]; record TDI at every rise.
  always_comb begin
    if (tdo_mode == 0)      vji_tdo = vji_tdi;
    else if (tdo_mode == 1) vji_tdo = 1'b1;
    else if (tdo_mode == 2) vji_tdo = 1'b0;
    else                    vji_tdo = rbits[rise_cnt[5:0]];
  end

  always @(posedge vji_tck) begin
    if (vji_uir) begin
      rise_cnt = 0;
    end else if (vji_sdr) begin
      tdi_seen[rise_cnt[5:0]] = vji_tdi;
      rise_cnt = rise_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " strobes"}, {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr}, 6'b0);
    check({tag, " rti"}, vji_rti, 1'b1);
    check({tag, " ir_in"}, vji_ir_in, 2'b00);
    check({tag, " ready"}, cmd_ready, 1'b1);
    check({tag, " rsp_valid"}, rsp_valid, 1'b0);
    check({tag, " rsp_data"}, rsp_data, '0);
    check({tag, " rsp_ir"}, rsp_ir_out, 2'b00);
  endtask

  task automatic run_scan(input string tag, input logic [1:0] ir, input logic [W-1:0] data,
                          input int mode, input logic [1:0] irout,
                          input logic [W-1:0] exp_rsp, input logic [1:0] exp_ir);
    int cnt, n_uir, n_cdr, n_sdr, n_udr, n_rti, n_ovl, n_irbad, n_tdibad;
    @(negedge clk);
    tdo_mode   = mode;
    vji_ir_out = irout;
    cmd_ir     = ir;
    cmd_data   = data;
    cmd_valid  = 1'b1;
    check({tag, " ready"}, cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    cmd_ir    = ~ir;
    cnt = 1; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
    n_ovl = 0; n_irbad = 0; n_tdibad = 0;
    while (!rsp_valid && cnt < LAT + 50) begin
      n_uir += int'(vji_uir);
      n_cdr += int'(vji_cdr);
      n_sdr += int'(vji_sdr);
      n_udr += int'(vji_udr);
      n_rti += int'(vji_rti);
      if (int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) > 1) n_ovl++;
      if (vji_ir_in !== ir) n_irbad++;
      if (!vji_sdr && vji_tdi !== 1'b0) n_tdibad++;
      @(negedge clk);
      cnt++;
    end
    check({tag, " latency"}, cnt, LAT);
    check({tag, " rsp_data"}, rsp_data, exp_rsp);
    check({tag, " rsp_ir_out"}, rsp_ir_out, exp_ir);
    check({tag, " ready@rsp"}, cmd_ready, 1'b1);
    check({tag, " tdi word"}, tdi_seen[W-1:0], data);
    check({tag, " sdr cycles"}, n_sdr, W * 2 * TD);
    check({tag, " uir/cdr/udr/rti"}, {n_uir[7:0], n_cdr[7:0], n_udr[7:0], n_rti[7:0]},
          {8'(2 * TD), 8'(2 * TD), 8'(2 * TD), 8'(2 * TD)});
    check({tag, " overlap/ir/tdi"}, {n_ovl[7:0], n_irbad[7:0], n_tdibad[7:0]}, 24'h0);
  endtask

  typedef struct {
    logic [1:0]   ir;
    logic [W-1:0] data;
    int           mode;
    logic [1:0]   ir_out;
    logic [W-1:0] exp_rsp;
    logic [1:0]   exp_ir;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cnt, ok, rises, guard, first_rise, period;
    logic prev;
    logic [W-1:0] rdata, rexp;
    logic [1:0] rir, rirout;

    vecs[0] = '{IrSelect, 38'h2A5A5A5A5A, 0, IrNop,    38'h2A5A5A5A5A, IrNop};
    vecs[1] = '{IrStatus, 38'h0123456789, 1, IrData,   38'h3FFFFFFFFF, IrData};
    vecs[2] = '{IrData,   38'h3FFFFFFFFF, 2, IrSelect, 38'h0,          IrSelect};
    vecs[3] = '{IrNop,    38'h0000000001, 0, IrStatus, 38'h1,          IrStatus};

    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_data = '0; vji_ir_out = 2'b00;
    s_reset = 1'b1; s_cmd_valid = 1'b0; s_cmd_ir = 2'b00; s_cmd_data = 2'b00; s_ir_out = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    s_reset = 1'b0;
    ok = 0;
    repeat (20) begin
      @(negedge clk);
      if (cmd_ready && vji_rti && !vji_tck && !vji_uir) ok++;
    end
    check("idle 20 cycles", ok, 20);

    for (int i = 0; i < 4; i++) begin
      run_scan($sformatf("vec%0d", i), vecs[i].ir, vecs[i].data, vecs[i].mode,
               vecs[i].ir_out, vecs[i].exp_rsp, vecs[i].exp_ir);
    end

    // Random commands: loopback returns the word, random TDO returns the slave's bit stream.
    for (int i = 0; i < 4; i++) begin
      rdata  = W'({$urandom, $urandom});
      rbits  = {$urandom, $urandom};
      rir    = 2'($urandom_range(0, 3));
      rirout = 2'($urandom_range(0, 3));
      rexp   = (i % 2 == 1) ? rbits[W-1:0] : rdata;
      run_scan($sformatf("rand%0d", i), rir, rdata, (i % 2 == 1) ? 3 : 0, rirout, rexp, rirout);
    end

    // Back-to-back: second command held valid from the first accept.
    @(negedge clk);
    tdo_mode = 0; cmd_valid = 1'b1; cmd_ir = IrSelect; cmd_data = 38'h1234567890;
    @(negedge clk);
    cmd_ir = IrData; cmd_data = 38'h0FEDCBA987;
    cnt = 1;
    while (!rsp_valid && cnt < LAT + 50) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b first latency", cnt, LAT);
    check("b2b first rsp", rsp_data, 38'h1234567890);
    check("b2b ready@rsp", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b second accept", {vji_ir_in, vji_uir}, {IrData, 1'b1});
    cnt = 1;
    while (!rsp_valid && cnt < LAT + 50) begin
      @(negedge clk);
      cnt++;
      cmd_valid = (cnt == 50);
    end
    cmd_valid = 1'b0;
    check("b2b rsp spacing", cnt, LAT);
    check("b2b second rsp", rsp_data, 38'h0FEDCBA987);
    ok = 0;
    repeat (30) begin
      @(negedge clk);
      ok += int'(vji_uir);
    end
    check("no queued cmd", ok, 0);

    // Reset together with cmd_valid: reset wins.
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b1; cmd_ir = IrStatus;
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    check("rst+valid dropped", {vji_uir, vji_ir_in, cmd_ready}, {1'b0, 2'b00, 1'b1});

    // Reset in the middle of shift-DR.
    @(negedge clk);
    tdo_mode = 0; cmd_valid = 1'b1; cmd_ir = IrSelect; cmd_data = 38'h15A5A5A5A5;
    @(negedge clk);
    cmd_valid = 1'b0;
    rises = 0; guard = 0; prev = vji_tck;
    while (rises < 10 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (vji_sdr && vji_tck && !prev) rises++;
      prev = vji_tck;
    end
    check("midrst reached 10 rises", rises, 10);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    ok = 0;
    repeat (200) begin
      @(negedge clk);
      ok += int'(rsp_valid) + int'(vji_uir);
    end
    check("midrst no rsp", ok, 0);
    run_scan("after midrst", IrData, 38'h2BADC0FFEE, 0, IrStatus, 38'h2BADC0FFEE, IrStatus);

    // Minimal configuration: TCK_DIV=1, DR_WIDTH=2.
    @(negedge clk);
    s_cmd_valid = 1'b1; s_cmd_ir = IrSelect; s_cmd_data = 2'b10; s_ir_out = IrData;
    @(negedge clk);
    s_cmd_valid = 1'b0;
    cnt = 1; first_rise = 0; period = 0; prev = s_tck;
    while (!s_rsp_valid && cnt < 50) begin
      if (s_tck && !prev) begin
        if (first_rise == 0) first_rise = cnt;
        else if (period == 0) period = cnt - first_rise;
      end
      prev = s_tck;
      @(negedge clk);
      cnt++;
    end
    check("small latency", cnt, 13);
    check("small rsp", s_rsp_data, 2'b10);
    check("small rsp_ir", s_rsp_ir_out, IrData);
    check("small tck period", period, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
